// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multi-cycle datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB/SPW, drives every datapath enable and
// mux select, times out stalled memory accesses and counts retired
// instructions.
module multicycle_control_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic             wb_src,
  output logic             alu_a_sel,
  output logic [1:0]       alu_mode,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_addr_sel,
  output logic             mem_data_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  // State encodings are visible on the debug port and must stay fixed.
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_SPW    = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LD    = 6'b010000;
  localparam logic [5:0] OP_ST    = 6'b010001;
  localparam logic [5:0] OP_MOVE  = 6'b010010;
  localparam logic [5:0] OP_PUSH  = 6'b010011;
  localparam logic [5:0] OP_POP   = 6'b010100;
  localparam logic [5:0] OP_CALL  = 6'b010101;
  localparam logic [5:0] OP_HALT  = 6'b010110;
  localparam logic [5:0] OP_NOP   = 6'b010111;
  localparam logic [5:0] OP_RET   = 6'b011000;
  localparam logic [5:0] OP_BR    = 6'b011001;
  localparam logic [5:0] OP_BZ    = 6'b011010;

  // Instruction classes; MOVE shares the I-type ALU class.
  localparam logic [3:0] C_R    = 4'd0;
  localparam logic [3:0] C_I    = 4'd1;
  localparam logic [3:0] C_LD   = 4'd2;
  localparam logic [3:0] C_ST   = 4'd3;
  localparam logic [3:0] C_BR   = 4'd4;
  localparam logic [3:0] C_BZ   = 4'd5;
  localparam logic [3:0] C_PUSH = 4'd6;
  localparam logic [3:0] C_POP  = 4'd7;
  localparam logic [3:0] C_CALL = 4'd8;
  localparam logic [3:0] C_RET  = 4'd9;
  localparam logic [3:0] C_HALT = 4'd10;
  localparam logic [3:0] C_NOP  = 4'd11;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  function automatic logic [3:0] classify(input logic [5:0] op);
    logic [3:0] c;
    case (op)
      OP_RTYPE: c = C_R;
      OP_MOVE:  c = C_I;
      OP_LD:    c = C_LD;
      OP_ST:    c = C_ST;
      OP_BR:    c = C_BR;
      OP_BZ:    c = C_BZ;
      OP_PUSH:  c = C_PUSH;
      OP_POP:   c = C_POP;
      OP_CALL:  c = C_CALL;
      OP_RET:   c = C_RET;
      OP_HALT:  c = C_HALT;
      OP_NOP:   c = C_NOP;
      default:  c = C_I;
    endcase
    return c;
  endfunction

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic             run_q;
  logic [3:0]       cls_q;
  logic [3:0]       cls_live;
  logic [7:0]       wait_q;
  logic             err_q;
  logic [CNT_W-1:0] retired_q;
  logic             mem_wait;
  logic             timeout;
  logic             retire;

  assign cls_live = classify(opcode);

  // run_q holds the sequencer idle for the first cycle after reset so every
  // strobe sits at its reset value for that cycle before FETCH starts.
  assign mem_wait = run_q && (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
  assign timeout  = mem_wait && (wait_q == WAIT_LAST);
  assign retire   = run_q && (state_d == S_FETCH) &&
                    (state_q != S_FETCH) && (state_q != S_HALT);

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready)    state_d = S_DECODE;
          else if (timeout) state_d = S_HALT;
        end
        S_DECODE: begin
          if (cls_live == C_HALT)     state_d = S_HALT;
          else if (cls_live == C_NOP) state_d = S_FETCH;
          else                        state_d = S_EXEC;
        end
        S_EXEC: begin
          case (cls_q)
            C_R, C_I:                                  state_d = S_WB;
            C_LD, C_ST, C_PUSH, C_POP, C_CALL, C_RET:  state_d = S_MEM;
            default:                                   state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            case (cls_q)
              C_LD, C_POP:          state_d = S_WB;
              C_RET, C_PUSH, C_CALL: state_d = S_SPW;
              default:              state_d = S_FETCH;
            endcase
          end else if (timeout) begin
            state_d = S_HALT;
          end
        end
        S_WB:    state_d = (cls_q == C_POP) ? S_SPW : S_FETCH;
        S_SPW:   state_d = S_FETCH;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State, latched class, wait counter, error flag and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      cls_q     <= C_R;
      wait_q    <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_live;
      if (mem_wait && !timeout) wait_q <= wait_q + 8'd1;
      else                      wait_q <= '0;
      if (timeout) err_q <= 1'b1;
      if (retire)  retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Output decode from state and latched class; FETCH's IR/PC write and
  // BZ's PC write follow mem_ready and zero within the cycle.
  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    reg_write    = 1'b0;
    reg_dst      = 2'd0;
    wb_src       = 1'b0;
    alu_a_sel    = 1'b0;
    alu_mode     = 2'd0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    mem_data_sel = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          case (cls_q)
            C_I, C_LD, C_ST: alu_mode = 2'd1;
            C_BR: begin
              pc_write = 1'b1;
              pc_src   = 2'd1;
            end
            C_BZ: begin
              pc_write = zero;
              pc_src   = 2'd1;
            end
            C_PUSH: begin
              alu_a_sel = 1'b1;
              alu_mode  = 2'd2;
            end
            C_CALL: alu_mode = 2'd2;
            C_POP: begin
              alu_a_sel = 1'b1;
              alu_mode  = 2'd1;
            end
            C_RET:   alu_mode = 2'd1;
            default: alu_mode = 2'd0;
          endcase
        end
        S_MEM: begin
          mem_addr_sel = 1'b1;
          case (cls_q)
            C_LD, C_POP, C_RET: mem_read = 1'b1;
            C_ST, C_PUSH:       mem_write = 1'b1;
            C_CALL: begin
              mem_write    = 1'b1;
              mem_data_sel = 1'b1;
            end
            default: mem_addr_sel = 1'b1;
          endcase
        end
        S_WB: begin
          reg_write = 1'b1;
          case (cls_q)
            C_R:  reg_dst = 2'd1;
            C_LD: wb_src = 1'b1;
            C_POP: begin
              reg_dst = 2'd2;
              wb_src  = 1'b1;
            end
            default: reg_dst = 2'd0;
          endcase
        end
        S_SPW: begin
          reg_write = 1'b1;
          reg_dst   = 2'd1;
          case (cls_q)
            C_PUSH: begin
              alu_a_sel = 1'b1;
              alu_mode  = 2'd2;
            end
            C_CALL: begin
              alu_mode = 2'd2;
              pc_write = 1'b1;
              pc_src   = 2'd1;
            end
            C_POP: begin
              alu_a_sel = 1'b1;
              alu_mode  = 2'd3;
            end
            C_RET: begin
              alu_mode = 2'd3;
              pc_write = 1'b1;
              pc_src   = 2'd2;
            end
            default: alu_mode = 2'd0;
          endcase
        end
        default: ir_write = 1'b0;
      endcase
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: table of per-instruction state/control
// paths plus hand-written memory-wait, timeout, reset and HALT sequences.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, reg_write, wb_src, alu_a_sel;
  logic        mem_read, mem_write, mem_addr_sel, mem_data_sel, halted, err;
  logic [1:0]  pc_src, reg_dst, alu_mode;
  logic [2:0]  state;
  logic [31:0] retired;

  multicycle_control_fsm #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src),
    .alu_a_sel(alu_a_sel), .alu_mode(alu_mode), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
    .mem_data_sel(mem_data_sel), .state(state), .halted(halted), .err(err),
    .retired(retired)
  );

  always #5 clk = ~clk;

  logic [14:0] act_cw;
  assign act_cw = {ir_write, pc_write, pc_src, reg_write, reg_dst, wb_src,
                   alu_a_sel, alu_mode, mem_read, mem_write, mem_addr_sel, mem_data_sel};

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [14:0] cw;
    logic        halted;
    logic        err;
    logic [31:0] ret;
  } exp_t;

  typedef struct {
    string            name;
    logic [5:0]       op;
    logic             zero;
    int unsigned      n;
    logic [0:5][2:0]  st;
    logic [0:5][14:0] cw;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        tbl[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_ret = '0;
  logic        exp_halt = 1'b0;
  logic        exp_err = 1'b0;

  logic [14:0] c0, cf, cwait, e_i, e_br, e_bz0, e_push, e_call, e_pop;
  logic [14:0] m_rd, m_wr, m_call, w_r, w_i, w_ld, w_pop;
  logic [14:0] s_push, s_call, s_pop, s_ret;

  function automatic logic [14:0] cw(input logic ir, pcw, input logic [1:0] pcs,
                                     input logic rw, input logic [1:0] rd,
                                     input logic wb, asel, input logic [1:0] am,
                                     input logic mr, mw, mas, mds);
    return {ir, pcw, pcs, rw, rd, wb, asel, am, mr, mw, mas, mds};
  endfunction

  task automatic check_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got no expectation, want one per cycle");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || act_cw !== e.cw || halted !== e.halted ||
          err !== e.err || retired !== e.ret) begin
        errors++;
        $display("FAIL %s: got state=%0d ctl=%h halted=%b err=%b retired=%0d, want state=%0d ctl=%h halted=%b err=%b retired=%0d",
                 e.name, state, act_cw, halted, err, retired,
                 e.st, e.cw, e.halted, e.err, e.ret);
      end
    end
  endtask

  task automatic step(input string nm, input logic [5:0] op, input logic z,
                      input logic rdy, input logic [2:0] st, input logic [14:0] w);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    e = '{nm, st, w, exp_halt, exp_err, exp_ret};
    exp_q.push_back(e);
    @(negedge clk);
    check_pop();
  endtask

  task automatic do_reset(input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    exp_ret  = '0;
    exp_halt = 1'b0;
    exp_err  = 1'b0;
    e = '{nm, 3'd0, 15'd0, 1'b0, 1'b0, 32'd0};
    exp_q.push_back(e);
    @(negedge clk);
    check_pop();
  endtask

  task automatic run_vec(input vec_t v);
    for (int unsigned i = 0; i < v.n; i++)
      step(v.name, (i < 2) ? v.op : ~v.op, v.zero, 1'b1, v.st[i], v.cw[i]);
    exp_ret = exp_ret + 32'd1;
  endtask

  task automatic add(input string nm, input logic [5:0] op, input logic z,
                     input int unsigned n, input logic [0:5][2:0] st,
                     input logic [0:5][14:0] w);
    vec_t v;
    v.name = nm; v.op = op; v.zero = z; v.n = n; v.st = st; v.cw = w;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, want finish before 100us");
    $fatal(1);
  end

  initial begin
    //            ir pcw pcs  rw rd   wb as am   mr mw mas mds
    c0     = '0;
    cf     = cw(1, 1, 2'd0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 0, 0);
    cwait  = cw(0, 0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 0, 0);
    e_i    = cw(0, 0, 2'd0, 0, 2'd0, 0, 0, 2'd1, 0, 0, 0, 0);
    e_br   = cw(0, 1, 2'd1, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0, 0);
    e_bz0  = cw(0, 0, 2'd1, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0, 0);
    e_push = cw(0, 0, 2'd0, 0, 2'd0, 0, 1, 2'd2, 0, 0, 0, 0);
    e_call = cw(0, 0, 2'd0, 0, 2'd0, 0, 0, 2'd2, 0, 0, 0, 0);
    e_pop  = cw(0, 0, 2'd0, 0, 2'd0, 0, 1, 2'd1, 0, 0, 0, 0);
    m_rd   = cw(0, 0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 1, 0);
    m_wr   = cw(0, 0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 0, 1, 1, 0);
    m_call = cw(0, 0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 0, 1, 1, 1);
    w_r    = cw(0, 0, 2'd0, 1, 2'd1, 0, 0, 2'd0, 0, 0, 0, 0);
    w_i    = cw(0, 0, 2'd0, 1, 2'd0, 0, 0, 2'd0, 0, 0, 0, 0);
    w_ld   = cw(0, 0, 2'd0, 1, 2'd0, 1, 0, 2'd0, 0, 0, 0, 0);
    w_pop  = cw(0, 0, 2'd0, 1, 2'd2, 1, 0, 2'd0, 0, 0, 0, 0);
    s_push = cw(0, 0, 2'd0, 1, 2'd1, 0, 1, 2'd2, 0, 0, 0, 0);
    s_call = cw(0, 1, 2'd1, 1, 2'd1, 0, 0, 2'd2, 0, 0, 0, 0);
    s_pop  = cw(0, 0, 2'd0, 1, 2'd1, 0, 1, 2'd3, 0, 0, 0, 0);
    s_ret  = cw(0, 1, 2'd2, 1, 2'd1, 0, 0, 2'd3, 0, 0, 0, 0);

    add("rtype", 6'b000000, 0, 4, {3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0},
        {cf, c0, c0, w_r, c0, c0});
    add("itype", 6'b001000, 0, 4, {3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0},
        {cf, c0, e_i, w_i, c0, c0});
    add("move", 6'b010010, 0, 4, {3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0},
        {cf, c0, e_i, w_i, c0, c0});
    add("ld", 6'b010000, 0, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0},
        {cf, c0, e_i, m_rd, w_ld, c0});
    add("st", 6'b010001, 0, 4, {3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0},
        {cf, c0, e_i, m_wr, c0, c0});
    add("br", 6'b011001, 0, 3, {3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0},
        {cf, c0, e_br, c0, c0, c0});
    add("bz_z0", 6'b011010, 0, 3, {3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0},
        {cf, c0, e_bz0, c0, c0, c0});
    add("bz_z1", 6'b011010, 1, 3, {3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0},
        {cf, c0, e_br, c0, c0, c0});
    add("push", 6'b010011, 0, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0},
        {cf, c0, e_push, m_wr, s_push, c0});
    add("pop", 6'b010100, 0, 6, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5},
        {cf, c0, e_pop, m_rd, w_pop, s_pop});
    add("call", 6'b010101, 0, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0},
        {cf, c0, e_call, m_call, s_call, c0});
    add("ret", 6'b011000, 0, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0},
        {cf, c0, e_i, m_rd, s_ret, c0});
    add("nop", 6'b010111, 0, 2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0},
        {cf, c0, c0, c0, c0, c0});
    add("itype_hi", 6'b111111, 1, 4, {3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0},
        {cf, c0, e_i, w_i, c0, c0});

    do_reset("reset_state");
    for (int unsigned i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // LD with three not-ready cycles in MEM: read held four cycles, no early WB
    step("ld_wait_f", 6'b000000, 0, 1, 3'd0, cf);
    step("ld_wait_d", 6'b010000, 0, 1, 3'd1, c0);
    step("ld_wait_e", 6'b101111, 0, 1, 3'd2, e_i);
    for (int unsigned i = 0; i < 3; i++)
      step("ld_wait_mem", 6'b101111, 0, 0, 3'd3, m_rd);
    step("ld_wait_done", 6'b101111, 0, 1, 3'd3, m_rd);
    step("ld_wait_wb", 6'b101111, 0, 1, 3'd4, w_ld);
    exp_ret = exp_ret + 32'd1;

    // Fourteen not-ready cycles in FETCH is one short of the timeout
    for (int unsigned i = 0; i < 14; i++)
      step("fetch_wait14", 6'b000000, 0, 0, 3'd0, cwait);
    step("fetch_wait14_done", 6'b000000, 0, 1, 3'd0, cf);
    step("fetch_wait14_nop", 6'b010111, 0, 1, 3'd1, c0);
    exp_ret = exp_ret + 32'd1;

    // Reset mid-wait clears state, outputs, retired count
    for (int unsigned i = 0; i < 5; i++)
      step("midwait_fetch", 6'b000000, 0, 0, 3'd0, cwait);
    do_reset("midwait_reset");

    // Fifteen not-ready cycles in FETCH times out into HALT with err
    for (int unsigned i = 0; i < 15; i++)
      step("timeout_fetch", 6'b000000, 0, 0, 3'd0, cwait);
    exp_halt = 1'b1;
    exp_err  = 1'b1;
    for (int unsigned i = 0; i < 3; i++)
      step("timeout_halt", 6'b010000, 0, logic'(i[0]), 3'd6, c0);

    // HALT opcode parks the core until reset, without err
    do_reset("halt_reset");
    step("halt_f", 6'b010110, 0, 1, 3'd0, cf);
    step("halt_d", 6'b010110, 0, 1, 3'd1, c0);
    exp_halt = 1'b1;
    for (int unsigned i = 0; i < 4; i++)
      step("halt_stay", 6'($urandom_range(0, 63)), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)), 3'd6, c0);

    do_reset("recover_reset");
    run_vec(tbl[0]);
    step("recover_retired", 6'b000000, 0, 0, 3'd0, cwait);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
